// File: rtl/decor_sequencer_if.sv
// Actuator handshake bundle: sound and effect request/code pairs with their acks.
interface decor_sequencer_if;
    logic       snd_req;
    logic [1:0] snd_code;
    logic       snd_ack;
    logic       fx_req;
    logic [1:0] fx_code;
    logic       fx_ack;

    modport master (
        output snd_req, snd_code, fx_req, fx_code,
        input  snd_ack, fx_ack
    );

    modport slave (
        input  snd_req, snd_code, fx_req, fx_code,
        output snd_ack, fx_ack
    );
endinterface

// File: rtl/decor_sequencer.sv
// Opcode-driven program sequencer: steps a 4-slot program, holding colours for a
// dwell time and issuing sound/effect commands over req/ack handshakes.
module decor_sequencer #(
    parameter int DWELL  = 4,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              on,
    // "program" is a reserved word, so the opcode slots arrive on prog
    input  logic [15:0]       prog,
    decor_sequencer_if.master act,
    output logic [1:0]        slot,
    output logic              busy,
    output logic              color_on,
    output logic [1:0]        color,
    output logic              err,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_COLOR_WAIT,
        S_SND_WAIT,
        S_FX_WAIT,
        S_ADVANCE
    } state_t;

    localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

    state_t              state_reg;
    logic [1:0]          slot_reg;
    logic [3:0]          op_reg;
    logic [7:0]          dwell_reg;
    logic                busy_reg;
    logic                color_on_reg;
    logic [1:0]          color_reg;
    logic                snd_req_reg;
    logic [1:0]          snd_code_reg;
    logic                fx_req_reg;
    logic [1:0]          fx_code_reg;
    logic                err_reg;
    logic [PASS_W-1:0]   pass_cnt_reg;

    logic [3:0] slot_op [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_op[gi] = prog[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            slot_reg     <= 2'd0;
            op_reg       <= 4'd0;
            dwell_reg    <= 8'd0;
            busy_reg     <= 1'b0;
            color_on_reg <= 1'b0;
            color_reg    <= 2'd0;
            snd_req_reg  <= 1'b0;
            snd_code_reg <= 2'd0;
            fx_req_reg   <= 1'b0;
            fx_code_reg  <= 2'd0;
            err_reg      <= 1'b0;
            pass_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (on) begin
                        state_reg <= S_FETCH;
                        busy_reg  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    op_reg    <= slot_op[slot_reg];
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    state_reg <= S_ADVANCE;
                    // A code of 11 is illegal in every class; in class 00 so is 10
                    unique case (op_reg[3:2])
                        2'b00: begin
                            if (op_reg[1:0] == 2'b01) begin
                                color_on_reg <= 1'b0;
                                color_reg    <= 2'd0;
                                slot_reg     <= 2'd0;
                                busy_reg     <= 1'b0;
                                state_reg    <= S_IDLE;
                            end else if (op_reg[1]) begin
                                err_reg <= 1'b1;
                            end
                        end
                        2'b01: begin
                            if (op_reg[1:0] == 2'b11) begin
                                err_reg <= 1'b1;
                            end else begin
                                color_on_reg <= 1'b1;
                                color_reg    <= op_reg[1:0];
                                dwell_reg    <= DWELL_LOAD;
                                state_reg    <= S_COLOR_WAIT;
                            end
                        end
                        2'b10: begin
                            if (op_reg[1:0] == 2'b11) begin
                                err_reg <= 1'b1;
                            end else begin
                                snd_req_reg  <= 1'b1;
                                snd_code_reg <= op_reg[1:0];
                                state_reg    <= S_SND_WAIT;
                            end
                        end
                        2'b11: begin
                            if (op_reg[1:0] == 2'b11) begin
                                err_reg <= 1'b1;
                            end else begin
                                fx_req_reg  <= 1'b1;
                                fx_code_reg <= op_reg[1:0];
                                state_reg   <= S_FX_WAIT;
                            end
                        end
                    endcase
                end
                S_COLOR_WAIT: begin
                    if (dwell_reg == 8'd0) begin
                        state_reg <= S_ADVANCE;
                    end else begin
                        dwell_reg <= dwell_reg - 8'd1;
                    end
                end
                S_SND_WAIT: begin
                    if (act.snd_ack) begin
                        snd_req_reg <= 1'b0;
                        state_reg   <= S_ADVANCE;
                    end
                end
                S_FX_WAIT: begin
                    if (act.fx_ack) begin
                        fx_req_reg <= 1'b0;
                        state_reg  <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    slot_reg <= slot_reg + 2'd1;
                    if (slot_reg == 2'd3) begin
                        pass_cnt_reg <= pass_cnt_reg + 1'b1;
                    end
                    busy_reg  <= on;
                    state_reg <= on ? S_FETCH : S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign slot         = slot_reg;
    assign busy         = busy_reg;
    assign color_on     = color_on_reg;
    assign color        = color_reg;
    assign err          = err_reg;
    assign pass_cnt     = pass_cnt_reg;
    assign act.snd_req  = snd_req_reg;
    assign act.snd_code = snd_code_reg;
    assign act.fx_req   = fx_req_reg;
    assign act.fx_code  = fx_code_reg;

endmodule

// File: tb/tb_decor_sequencer.sv
// Bench for decor_sequencer: directed scenarios plus random programs checked
// against a step-level model of what each opcode should do.
module tb_decor_sequencer;
    localparam int DW = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          on = 1'b0;
    logic [15:0]   prog = 16'd0;
    logic [1:0]    slot;
    logic          busy;
    logic          color_on;
    logic [1:0]    color;
    logic          err;
    logic [PW-1:0] pass_cnt;

    decor_sequencer_if act();

    decor_sequencer #(.DWELL(DW), .PASS_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .on       (on),
        .prog     (prog),
        .act      (act.master),
        .slot     (slot),
        .busy     (busy),
        .color_on (color_on),
        .color    (color),
        .err      (err),
        .pass_cnt (pass_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        act.snd_ack = 1'b0;
        act.fx_ack  = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        on  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            act.snd_ack = i[0];
            act.fx_ack  = ~i[0];
            tick();
        end
        total++;
        if ({slot, busy, color_on, color, err, pass_cnt, act.snd_req, act.fx_req} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got slot=%0d busy=%0b con=%0b col=%0d err=%0b pass=%0d sreq=%0b freq=%0b exp all 0",
                     slot, busy, color_on, color, err, pass_cnt, act.snd_req, act.fx_req);
        end
        act.snd_ack = 1'b0;
        act.fx_ack  = 1'b0;
        on  = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || slot !== 2'd0) begin
            bad++;
            $display("FAIL reset_idle got busy=%0b slot=%0d exp busy=0 slot=0", busy, slot);
        end
    endtask

    // Program: slot0 green, slot1 purple, slot2 illegal, slot3 movejaw
    task automatic test_color();
        int cnt;
        prog = 16'b1101_1111_0101_0100;
        on = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1 || slot !== 2'd0) begin
            bad++;
            $display("FAIL color_fetch got busy=%0b slot=%0d exp busy=1 slot=0", busy, slot);
        end
        tick();
        total++;
        if (color_on !== 1'b0) begin
            bad++;
            $display("FAIL color_exec_early got color_on=%0b exp 0", color_on);
        end
        tick();
        cnt = 0;
        while (color !== 2'd1 && cnt < 20) begin
            if (cnt < DW) begin
                total++;
                if (color_on !== 1'b1 || color !== 2'd0 || slot !== 2'd0) begin
                    bad++;
                    $display("FAIL color_green_hold cyc=%0d got con=%0b col=%0d slot=%0d exp con=1 col=0 slot=0",
                             cnt, color_on, color, slot);
                end
            end
            tick();
            cnt++;
        end
        total++;
        if (cnt !== DW + 3 || slot !== 2'd1 || color_on !== 1'b1) begin
            bad++;
            $display("FAIL color_purple_delay got cyc=%0d slot=%0d con=%0b exp cyc=%0d slot=1 con=1",
                     cnt, slot, color_on, DW + 3);
        end
    endtask

    task automatic test_illegal();
        repeat (DW) tick();
        tick();
        total++;
        if (slot !== 2'd2 || err !== 1'b0) begin
            bad++;
            $display("FAIL illegal_fetch got slot=%0d err=%0b exp slot=2 err=0", slot, err);
        end
        tick();
        tick();
        total++;
        if (err !== 1'b1 || color !== 2'd1 || color_on !== 1'b1) begin
            bad++;
            $display("FAIL illegal_err got err=%0b col=%0d con=%0b exp err=1 col=1 con=1", err, color, color_on);
        end
        tick();
        total++;
        if (slot !== 2'd3) begin
            bad++;
            $display("FAIL illegal_advance got slot=%0d exp 3", slot);
        end
    endtask

    task automatic test_fx_handshake();
        tick();
        tick();
        total++;
        if (act.fx_req !== 1'b1 || act.fx_code !== 2'd1) begin
            bad++;
            $display("FAIL fx_issue got req=%0b code=%0d exp req=1 code=1", act.fx_req, act.fx_code);
        end
        for (int i = 0; i < 10; i++) begin
            act.snd_ack = i[0];
            tick();
            total++;
            if (act.fx_req !== 1'b1 || act.snd_req !== 1'b0 || slot !== 2'd3) begin
                bad++;
                $display("FAIL fx_hold cyc=%0d got freq=%0b sreq=%0b slot=%0d exp 1 0 3",
                         i, act.fx_req, act.snd_req, slot);
            end
        end
        act.snd_ack = 1'b0;
        act.fx_ack  = 1'b1;
        tick();
        act.fx_ack  = 1'b0;
        total++;
        if (act.fx_req !== 1'b0) begin
            bad++;
            $display("FAIL fx_release got req=%0b exp 0", act.fx_req);
        end
        tick();
        total++;
        if (slot !== 2'd0 || pass_cnt !== 8'd1) begin
            bad++;
            $display("FAIL fx_wrap got slot=%0d pass=%0d exp slot=0 pass=1", slot, pass_cnt);
        end
    endtask

    // Currently in FETCH of slot0 (green): drop on mid-dwell, expect clean stop
    task automatic test_stop();
        tick();
        tick();
        on = 1'b0;
        repeat (DW) tick();
        total++;
        if (busy !== 1'b1 || slot !== 2'd0) begin
            bad++;
            $display("FAIL stop_advance got busy=%0b slot=%0d exp busy=1 slot=0", busy, slot);
        end
        tick();
        repeat (3) begin
            total++;
            if (busy !== 1'b0 || slot !== 2'd1) begin
                bad++;
                $display("FAIL stop_idle got busy=%0b slot=%0d exp busy=0 slot=1", busy, slot);
            end
            tick();
        end
    endtask

    task automatic test_sound_reset();
        do_reset();
        prog = 16'b0001_1010_0000_0000;
        on = 1'b1;
        tick();
        repeat (3) tick();
        total++;
        if (slot !== 2'd1) begin
            bad++;
            $display("FAIL snd_noop0 got slot=%0d exp 1", slot);
        end
        repeat (3) tick();
        total++;
        if (slot !== 2'd2) begin
            bad++;
            $display("FAIL snd_noop1 got slot=%0d exp 2", slot);
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            act.fx_ack = (i == 1);
            total++;
            if (act.snd_req !== 1'b1 || act.snd_code !== 2'd2) begin
                bad++;
                $display("FAIL snd_hold cyc=%0d got req=%0b code=%0d exp req=1 code=2", i, act.snd_req, act.snd_code);
            end
            tick();
        end
        act.fx_ack  = 1'b0;
        act.snd_ack = 1'b1;
        tick();
        act.snd_ack = 1'b0;
        total++;
        if (act.snd_req !== 1'b0) begin
            bad++;
            $display("FAIL snd_release got req=%0b exp 0", act.snd_req);
        end
        tick();
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || slot !== 2'd0 || color_on !== 1'b0) begin
            bad++;
            $display("FAIL snd_reset_op got busy=%0b slot=%0d con=%0b exp 0 0 0", busy, slot, color_on);
        end
        tick();
        total++;
        if (busy !== 1'b1 || slot !== 2'd0) begin
            bad++;
            $display("FAIL snd_restart got busy=%0b slot=%0d exp busy=1 slot=0", busy, slot);
        end
        // Run back to the sound step and hit reset while the request is pending
        repeat (8) tick();
        total++;
        if (act.snd_req !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre got req=%0b exp 1", act.snd_req);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (act.snd_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_async got req=%0b busy=%0b exp 0 0", act.snd_req, busy);
        end
        on = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || slot !== 2'd0) begin
            bad++;
            $display("FAIL abort_idle got busy=%0b slot=%0d exp 0 0", busy, slot);
        end
    endtask

    task automatic test_random();
        logic [15:0]   m_prog;
        logic [1:0]    m_slot;
        logic [PW-1:0] m_pass;
        logic          m_con;
        logic [1:0]    m_col;
        logic          m_err;
        logic [3:0]    op;
        logic [1:0]    code;
        int            w;
        for (int p = 0; p < 6; p++) begin
            do_reset();
            m_prog = 16'($urandom);
            prog   = m_prog;
            m_slot = 2'd0; m_pass = '0; m_con = 1'b0; m_col = 2'd0; m_err = 1'b0;
            on = 1'b1;
            tick();
            for (int s = 0; s < 12; s++) begin
                op   = 4'(m_prog >> (4 * m_slot));
                code = op[1:0];
                total++;
                if (busy !== 1'b1 || slot !== m_slot || pass_cnt !== m_pass || color_on !== m_con ||
                    color !== m_col || err !== m_err) begin
                    bad++;
                    $display("FAIL rand_step p=%0d s=%0d op=%b got busy=%0b slot=%0d pass=%0d con=%0b col=%0d err=%0b exp 1 %0d %0d %0b %0d %0b",
                             p, s, op, busy, slot, pass_cnt, color_on, color, err, m_slot, m_pass, m_con, m_col, m_err);
                end
                tick();
                tick();
                if (op == 4'b0001) begin
                    m_con = 1'b0; m_col = 2'd0; m_slot = 2'd0;
                    total++;
                    if (busy !== 1'b0 || slot !== 2'd0 || color_on !== 1'b0) begin
                        bad++;
                        $display("FAIL rand_reset_op p=%0d got busy=%0b slot=%0d con=%0b exp 0 0 0", p, busy, slot, color_on);
                    end
                    tick();
                    continue;
                end
                if (code == 2'd3 || op == 4'b0010) m_err = 1'b1;
                else if (op[3:2] == 2'b01) begin
                    m_con = 1'b1; m_col = code;
                    total++;
                    if (color_on !== 1'b1 || color !== code) begin
                        bad++;
                        $display("FAIL rand_color p=%0d got con=%0b col=%0d exp 1 %0d", p, color_on, color, code);
                    end
                    repeat (DW) tick();
                end else if (op[3:2] == 2'b10 || op[3:2] == 2'b11) begin
                    w = $urandom_range(0, 4);
                    for (int k = 0; k <= w; k++) begin
                        total++;
                        if (op[3:2] == 2'b10 ? (act.snd_req !== 1'b1 || act.snd_code !== code || act.fx_req !== 1'b0)
                                             : (act.fx_req !== 1'b1 || act.fx_code !== code || act.snd_req !== 1'b0)) begin
                            bad++;
                            $display("FAIL rand_hs p=%0d op=%b cyc=%0d got sreq=%0b scode=%0d freq=%0b fcode=%0d",
                                     p, op, k, act.snd_req, act.snd_code, act.fx_req, act.fx_code);
                        end
                        if (k < w) begin
                            if (op[3:2] == 2'b10) act.fx_ack = 1'($urandom);
                            else                  act.snd_ack = 1'($urandom);
                            tick();
                        end
                    end
                    act.snd_ack = (op[3:2] == 2'b10);
                    act.fx_ack  = (op[3:2] == 2'b11);
                    tick();
                    act.snd_ack = 1'b0;
                    act.fx_ack  = 1'b0;
                    total++;
                    if (act.snd_req !== 1'b0 || act.fx_req !== 1'b0) begin
                        bad++;
                        $display("FAIL rand_hs_release p=%0d got sreq=%0b freq=%0b exp 0 0", p, act.snd_req, act.fx_req);
                    end
                end
                tick();
                if (m_slot == 2'd3) m_pass = m_pass + 1'b1;
                m_slot = m_slot + 2'd1;
            end
        end
        on = 1'b0;
    endtask

    initial begin
        act.snd_ack = 1'b0;
        act.fx_ack  = 1'b0;
        test_reset();
        test_color();
        test_illegal();
        test_fx_handshake();
        test_stop();
        test_sound_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
